// File: rtl/fc_train_sequencer.sv
// fc_train_sequencer: runs one FC-layer training step per start.
// The step is a forward pass (input buffer -> core), an argmax over the ReLU outputs,
// then a backprop pass (output - one-hot target -> core), and finally a drain of the
// core's input-error words into the upstream error buffer.
module fc_train_sequencer #(
  parameter int unsigned INPUT_WIDTH   = 1024,
  parameter int unsigned OUTPUT_WIDTH  = 10,
  parameter int unsigned IDX_WIDTH     = 10,
  parameter int unsigned IN_ADDR_WIDTH = 10,
  parameter int unsigned O_ADDR_WIDTH  = 4,
  parameter logic [31:0] ONE           = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [O_ADDR_WIDTH-1:0]  label,
  output logic                     busy,
  output logic                     done,
  output logic [O_ADDR_WIDTH-1:0]  pred_class,
  output logic [IN_ADDR_WIDTH-1:0] in_addr,
  input  logic [31:0]              in_data,
  output logic                     fc_forward,
  output logic                     fc_in_valid,
  input  logic                     fc_in_rdy,
  output logic [31:0]              fc_input,
  output logic [IDX_WIDTH-1:0]     fc_input_idx,
  input  logic                     fc_out_valid,
  output logic                     fc_out_rdy,
  input  logic [31:0]              fc_output,
  input  logic [IDX_WIDTH-1:0]     fc_output_idx,
  output logic                     err_we,
  output logic [IN_ADDR_WIDTH-1:0] err_addr,
  output logic [31:0]              err_data
);

  localparam logic [IN_ADDR_WIDTH-1:0] LP_IN_LAST      = IN_ADDR_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0]     LP_IDX_IN_LAST  = IDX_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0]     LP_IDX_OUT_LAST = IDX_WIDTH'(OUTPUT_WIDTH - 1);
  localparam logic [O_ADDR_WIDTH-1:0]  LP_K_LAST       = O_ADDR_WIDTH'(OUTPUT_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FWD_FETCH, S_FWD_SEND, S_FWD_COLLECT, S_BWD_SEND, S_BWD_DRAIN, S_DONE
  } state_t;

  state_t                   r_state;
  logic [O_ADDR_WIDTH-1:0]  r_label;
  logic                     r_busy;
  logic                     r_done;
  logic [O_ADDR_WIDTH-1:0]  r_pred;
  logic [IN_ADDR_WIDTH-1:0] r_in_addr;
  logic [IN_ADDR_WIDTH-1:0] r_elem;
  logic                     r_fc_forward;
  logic                     r_fc_in_valid;
  logic [31:0]              r_fc_input;
  logic [IDX_WIDTH-1:0]     r_fc_input_idx;
  logic                     r_fc_out_rdy;
  logic                     r_err_we;
  logic [IN_ADDR_WIDTH-1:0] r_err_addr;
  logic [31:0]              r_err_data;
  logic [31:0]              r_out [OUTPUT_WIDTH];
  logic [31:0]              r_max;
  logic [O_ADDR_WIDTH-1:0]  r_arg;
  logic [O_ADDR_WIDTH-1:0]  r_k;

  logic                     w_in_hs;
  logic                     w_out_hs;
  logic                     w_idx_in_range;
  logic [O_ADDR_WIDTH-1:0]  w_out_cls;
  logic                     w_take;
  logic [O_ADDR_WIDTH-1:0]  w_arg_next;
  logic [31:0]              w_grad;

  // Handshakes, running-argmax update and output gradient for the current class
  assign w_in_hs        = r_fc_in_valid & fc_in_rdy;
  assign w_out_hs       = fc_out_valid & r_fc_out_rdy;
  assign w_idx_in_range = (fc_output_idx <= LP_IDX_OUT_LAST);
  assign w_out_cls      = O_ADDR_WIDTH'(fc_output_idx);
  assign w_take         = (fc_output > r_max) || ((fc_output == r_max) && (w_out_cls < r_arg));
  assign w_arg_next     = (w_out_hs && w_idx_in_range && w_take) ? w_out_cls : r_arg;
  assign w_grad         = r_out[r_k] - ((r_k == r_label) ? ONE : 32'd0);

  // Step sequencer; in_addr runs one element ahead of the element being sent so the
  // sync-read buffer data is already settled when FWD_FETCH samples it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_label        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pred         <= '0;
      r_in_addr      <= '0;
      r_elem         <= '0;
      r_fc_forward   <= 1'b1;
      r_fc_in_valid  <= 1'b0;
      r_fc_input     <= '0;
      r_fc_input_idx <= '0;
      r_fc_out_rdy   <= 1'b0;
      r_err_we       <= 1'b0;
      r_err_addr     <= '0;
      r_err_data     <= '0;
      r_out          <= '{default: '0};
      r_max          <= '0;
      r_arg          <= '0;
      r_k            <= '0;
    end else begin
      r_done   <= 1'b0;
      r_err_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fc_forward <= 1'b1;
          r_in_addr    <= '0;
          if (start) begin
            r_label <= label;
            r_busy  <= 1'b1;
            r_elem  <= '0;
            r_state <= S_FWD_FETCH;
          end
        end
        S_FWD_FETCH: begin
          r_fc_input     <= in_data;
          r_fc_input_idx <= IDX_WIDTH'(r_elem);
          r_fc_in_valid  <= 1'b1;
          if (r_elem != LP_IN_LAST) r_in_addr <= r_elem + IN_ADDR_WIDTH'(1);
          r_state        <= S_FWD_SEND;
        end
        S_FWD_SEND: begin
          if (w_in_hs) begin
            r_fc_in_valid <= 1'b0;
            if (r_elem == LP_IN_LAST) begin
              r_fc_out_rdy <= 1'b1;
              r_max        <= '0;
              r_arg        <= '0;
              r_state      <= S_FWD_COLLECT;
            end else begin
              r_elem  <= r_elem + IN_ADDR_WIDTH'(1);
              r_state <= S_FWD_FETCH;
            end
          end
        end
        S_FWD_COLLECT: begin
          if (w_out_hs && w_idx_in_range) begin
            r_out[w_out_cls] <= fc_output;
            if (w_take) begin
              r_max <= fc_output;
              r_arg <= w_out_cls;
            end
            if (fc_output_idx == LP_IDX_OUT_LAST) begin
              r_pred       <= w_arg_next;
              r_fc_out_rdy <= 1'b0;
              r_fc_forward <= 1'b0;
              r_k          <= '0;
              r_state      <= S_BWD_SEND;
            end
          end
        end
        S_BWD_SEND: begin
          if (!r_fc_in_valid) begin
            r_fc_input     <= w_grad;
            r_fc_input_idx <= IDX_WIDTH'(r_k);
            r_fc_in_valid  <= 1'b1;
          end else if (fc_in_rdy) begin
            r_fc_in_valid <= 1'b0;
            if (r_k == LP_K_LAST) begin
              r_fc_out_rdy <= 1'b1;
              r_state      <= S_BWD_DRAIN;
            end else begin
              r_k <= r_k + O_ADDR_WIDTH'(1);
            end
          end
        end
        S_BWD_DRAIN: begin
          if (w_out_hs) begin
            r_err_we   <= 1'b1;
            r_err_addr <= fc_output_idx[IN_ADDR_WIDTH-1:0];
            r_err_data <= fc_output;
            if (fc_output_idx == LP_IDX_IN_LAST) begin
              r_fc_out_rdy <= 1'b0;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_fc_forward <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_in_addr <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign pred_class   = r_pred;
  assign in_addr      = r_in_addr;
  assign fc_forward   = r_fc_forward;
  assign fc_in_valid  = r_fc_in_valid;
  assign fc_input     = r_fc_input;
  assign fc_input_idx = r_fc_input_idx;
  assign fc_out_rdy   = r_fc_out_rdy;
  assign err_we       = r_err_we;
  assign err_addr     = r_err_addr;
  assign err_data     = r_err_data;

endmodule

// File: tb/tb_fc_train_sequencer.sv
// Directed bench for fc_train_sequencer: sync-read input buffer plus a simple core model.
module tb_fc_train_sequencer;

  localparam int unsigned INPUT_WIDTH   = 1024;
  localparam int unsigned OUTPUT_WIDTH  = 10;
  localparam int unsigned IDX_WIDTH     = 10;
  localparam int unsigned IN_ADDR_WIDTH = 10;
  localparam int unsigned O_ADDR_WIDTH  = 4;
  localparam logic [31:0] ONE           = 32'h0001_0000;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [O_ADDR_WIDTH-1:0]  label;
  logic                     busy;
  logic                     done;
  logic [O_ADDR_WIDTH-1:0]  pred_class;
  logic [IN_ADDR_WIDTH-1:0] in_addr;
  logic [31:0]              in_data;
  logic                     fc_forward;
  logic                     fc_in_valid;
  logic                     fc_in_rdy;
  logic [31:0]              fc_input;
  logic [IDX_WIDTH-1:0]     fc_input_idx;
  logic                     fc_out_valid;
  logic                     fc_out_rdy;
  logic [31:0]              fc_output;
  logic [IDX_WIDTH-1:0]     fc_output_idx;
  logic                     err_we;
  logic [IN_ADDR_WIDTH-1:0] err_addr;
  logic [31:0]              err_data;

  logic [31:0] mem  [INPUT_WIDTH];
  logic [31:0] outs [OUTPUT_WIDTH];

  int n_checks = 0;
  int n_errors = 0;

  fc_train_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .label(label), .busy(busy), .done(done),
    .pred_class(pred_class), .in_addr(in_addr), .in_data(in_data),
    .fc_forward(fc_forward), .fc_in_valid(fc_in_valid), .fc_in_rdy(fc_in_rdy),
    .fc_input(fc_input), .fc_input_idx(fc_input_idx), .fc_out_valid(fc_out_valid),
    .fc_out_rdy(fc_out_rdy), .fc_output(fc_output), .fc_output_idx(fc_output_idx),
    .err_we(err_we), .err_addr(err_addr), .err_data(err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read input buffer
  always @(posedge clk) in_data <= mem[in_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_busy"},       32'(busy),         32'd0);
    check_val({tag, "_done"},       32'(done),         32'd0);
    check_val({tag, "_pred"},       32'(pred_class),   32'd0);
    check_val({tag, "_in_addr"},    32'(in_addr),      32'd0);
    check_val({tag, "_fwd"},        32'(fc_forward),   32'd1);
    check_val({tag, "_in_valid"},   32'(fc_in_valid),  32'd0);
    check_val({tag, "_input"},      fc_input,          32'd0);
    check_val({tag, "_input_idx"},  32'(fc_input_idx), 32'd0);
    check_val({tag, "_out_rdy"},    32'(fc_out_rdy),   32'd0);
    check_val({tag, "_err_we"},     32'(err_we),       32'd0);
    check_val({tag, "_err_addr"},   32'(err_addr),     32'd0);
    check_val({tag, "_err_data"},   err_data,          32'd0);
  endtask

  task automatic wait_busy(input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!busy && cyc < 4);
    check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  // Forward stream: in-order indices, data = idx<<16, one idle cycle after each transfer
  task automatic fwd_phase(input bit stall_en);
    int n = 0, cyc = 0, order_err = 0, data_err = 0, b2b = 0, hold_err = 0;
    int stall = 0, n17 = 0, rdy_leak = 0, mode_err = 0;
    bit prev_xfer = 1'b0;
    logic [31:0] hd = '0;
    fc_out_valid  = 1'b1;
    fc_output_idx = 10'd9;
    fc_output     = 32'hFFFF_0000;
    while (n < INPUT_WIDTH && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (fc_out_rdy) rdy_leak++;
      if (fc_in_valid && prev_xfer) b2b++;
      if (!fc_in_valid) begin
        fc_in_rdy = 1'($urandom_range(0, 1));
      end else if (stall_en && fc_input_idx == 10'd17 && stall < 5) begin
        if (stall == 0) hd = fc_input;
        else if (fc_input !== hd || fc_input_idx !== 10'd17) hold_err++;
        fc_in_rdy = 1'b0;
        stall++;
      end else begin
        fc_in_rdy = 1'b1;
      end
      prev_xfer = fc_in_valid && fc_in_rdy;
      if (prev_xfer) begin
        if (fc_input_idx !== IDX_WIDTH'(n)) order_err++;
        if (fc_input !== (32'(n) << 16)) data_err++;
        if (!fc_forward) mode_err++;
        if (fc_input_idx == 10'd17) begin
          n17++;
          if (stall_en && fc_input !== hd) hold_err++;
        end
        n++;
        if (n == INPUT_WIDTH) fc_out_valid = 1'b0;
      end
    end
    fc_out_valid = 1'b0;
    check_val("fwd_count",     32'(n),        32'd1024);
    check_val("fwd_order",     32'(order_err), 32'd0);
    check_val("fwd_data",      32'(data_err),  32'd0);
    check_val("fwd_idle_gap",  32'(b2b),       32'd0);
    check_val("fwd_mode",      32'(mode_err),  32'd0);
    check_val("fwd_rdy_leak",  32'(rdy_leak),  32'd0);
    check_val("fwd_idx17_once", 32'(n17),      32'd1);
    if (stall_en) begin
      check_val("fwd_stall_cycles", 32'(stall),    32'd5);
      check_val("fwd_stall_hold",   32'(hold_err), 32'd0);
    end
  endtask

  // Core outputs: an out-of-range idx 12 first (must be dropped), then classes 0..9
  task automatic collect_phase(input logic [O_ADDR_WIDTH-1:0] exp_pred);
    int j = 0, cyc = 0;
    bit pend = 1'b0;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (pend) j++;
      if (j == 11) begin
        fc_out_valid = 1'b0;
        break;
      end
      fc_out_valid  = 1'b1;
      fc_output_idx = (j == 0) ? 10'd12 : IDX_WIDTH'(j - 1);
      fc_output     = (j == 0) ? 32'h7FFF_0000 : outs[O_ADDR_WIDTH'(j - 1)];
      pend          = fc_out_rdy;
    end
    fc_out_valid = 1'b0;
    check_val("collect_count",  32'(j),          32'd11);
    check_val("collect_rdy_lo", 32'(fc_out_rdy), 32'd0);
    check_val("pred_class",     32'(pred_class), 32'(exp_pred));
  endtask

  // Backprop stream: out[k] - (k==label ? 1.0 : 0); optional reset while k=4 is presented
  task automatic bwd_phase(input logic [O_ADDR_WIDTH-1:0] lbl, input bit rst_k4, output bit aborted);
    logic [O_ADDR_WIDTH-1:0] k = '0;
    int n = 0, cyc = 0, b2b = 0, fwd_err = 0;
    bit prev_xfer = 1'b0;
    logic [31:0] exp;
    aborted = 1'b0;
    while (n < OUTPUT_WIDTH && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (rst_k4 && fc_in_valid && fc_input_idx == 10'd4) begin
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        aborted = 1'b1;
        return;
      end
      if (fc_in_valid && prev_xfer) b2b++;
      if (fc_forward !== 1'b0) fwd_err++;
      fc_in_rdy = fc_in_valid ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      prev_xfer = fc_in_valid && fc_in_rdy;
      if (prev_xfer) begin
        exp = outs[k] - ((k == lbl) ? ONE : 32'd0);
        check_val("bwd_idx",  32'(fc_input_idx), 32'(k));
        check_val("bwd_data", fc_input, exp);
        k = k + 4'd1;
        n++;
      end
    end
    check_val("bwd_count",    32'(n),       32'd10);
    check_val("bwd_idle_gap", 32'(b2b),     32'd0);
    check_val("bwd_mode",     32'(fwd_err), 32'd0);
  endtask

  // Error drain with random valid gaps; err_we pulses mirror the accepted words
  task automatic drain_phase();
    int sent = 0, got = 0, cyc = 0, dones = 0, addr_err = 0, data_err = 0, busy_err = 0;
    bit pend = 1'b0;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pend) sent++;
      if (err_we) begin
        if (err_addr !== IN_ADDR_WIDTH'(got)) addr_err++;
        if (err_data !== (32'hC0DE_0000 ^ 32'(got))) data_err++;
        got++;
      end
      if (done) begin
        dones++;
        check_val("done_busy_low", 32'(busy), 32'd0);
        check_val("done_fwd",      32'(fc_forward), 32'd1);
        break;
      end
      if (!busy) busy_err++;
      if (sent < INPUT_WIDTH) begin
        fc_out_valid  = 1'($urandom_range(0, 1));
        fc_output_idx = IDX_WIDTH'(sent);
        fc_output     = 32'hC0DE_0000 ^ 32'(sent);
        pend          = fc_out_valid && fc_out_rdy;
      end else begin
        fc_out_valid = 1'b0;
        pend         = 1'b0;
      end
    end
    fc_out_valid = 1'b0;
    check_val("drain_sent",     32'(sent),     32'd1024);
    check_val("drain_err_we",   32'(got),      32'd1024);
    check_val("drain_addr",     32'(addr_err), 32'd0);
    check_val("drain_data",     32'(data_err), 32'd0);
    check_val("drain_done",     32'(dones),    32'd1);
    check_val("drain_busy",     32'(busy_err), 32'd0);
    @(negedge clk);
    check_val("post_done_pulse", 32'(done), 32'd0);
    check_val("post_done_idle",  32'(busy), 32'd0);
  endtask

  task automatic run_step(input logic [O_ADDR_WIDTH-1:0] lbl, input bit stall_en, input bit rst_k4);
    bit aborted;
    fwd_phase(stall_en);
    collect_phase(4'd3);
    bwd_phase(lbl, rst_k4, aborted);
    if (!aborted) drain_phase();
  endtask

  initial begin
    for (int i = 0; i < INPUT_WIDTH; i++) mem[IN_ADDR_WIDTH'(i)] = 32'(i) << 16;
    outs = '{32'h0000_0000, 32'h0005_0000, 32'h0003_0000, 32'h0009_0000, 32'h0009_0000,
             32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 32'h0007_0000};
    rst_n = 1'b0; start = 1'b0; label = '0;
    fc_in_rdy = 1'b1; fc_out_valid = 1'b0; fc_output = '0; fc_output_idx = '0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    // Step A: label 3, stall on element 17, start held high, label changed mid-step
    label = 4'd3;
    start = 1'b1;
    wait_busy("a");
    label = 4'd0;
    run_step(4'd3, 1'b1, 1'b0);

    // Step B: restarts only from IDLE because start is still high; label 0
    wait_busy("b");
    run_step(4'd0, 1'b0, 1'b0);

    // Step C: aborted by reset while k=4 is presented in backprop
    wait_busy("c");
    start = 1'b0;
    run_step(4'd0, 1'b0, 1'b1);
    fc_out_valid = 1'b0;
    fc_in_rdy    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_abort");

    // Step D: fresh single-pulse start, label 7
    label = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("d_busy_rise", 32'(busy), 32'd1);
    run_step(4'd7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
